// File: rtl/mplier_rr_sched_if.sv
// Requester and result handshake bundle for the shared-multiplier scheduler.
interface mplier_rr_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_mplier;
  logic [NREQ*32-1:0] req_mcand;
  logic               res_valid;
  logic               res_ready;
  logic [63:0]        res_product;
  logic [IDW-1:0]     res_id;

  // Requesters and result consumer side
  modport master (
    output req_valid, req_mplier, req_mcand, res_ready,
    input  req_ready, res_valid, res_product, res_id
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_mplier, req_mcand, res_ready,
    output req_ready, res_valid, res_product, res_id
  );
endinterface

// File: rtl/mplier_rr_sched.sv
// Round-robin scheduler sharing one external combinational 32x32 signed multiplier
// among NREQ requesters through a two-stage (issue, result) pipeline.
module mplier_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mplier_rr_sched_if.slave        bus,
  output logic [31:0]             mul_mplier,
  output logic [31:0]             mul_mcand,
  input  logic [63:0]             mul_product,
  output logic                    busy
);

  logic           iss_valid_q;
  logic [31:0]    iss_a_q;
  logic [31:0]    iss_b_q;
  logic [IDW-1:0] iss_id_q;
  logic           res_valid_q;
  logic [63:0]    res_product_q;
  logic [IDW-1:0] res_id_q;
  logic [IDW-1:0] ptr_q;

  logic           res_adv;
  logic           iss_adv;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           xfer;
  logic [31:0]    gnt_a;
  logic [31:0]    gnt_b;
  logic [IDW-1:0] ptr_next;

  assign res_adv = !res_valid_q || bus.res_ready;
  assign iss_adv = !iss_valid_q || res_adv;

  // Rotating-priority scan: first valid requester at or after ptr, wrapping at NREQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // One-hot accept; held off during reset so nothing looks accepted while flops are cleared
  always_comb begin
    xfer          = gnt_found && iss_adv && rst_n;
    bus.req_ready = '0;
    if (xfer) begin
      bus.req_ready[gnt_id] = 1'b1;
    end
  end

  // Operand select for the granted requester
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_id == IDW'(i)) begin
        gnt_a = bus.req_mplier[32*i +: 32];
        gnt_b = bus.req_mcand[32*i +: 32];
      end
    end
    ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Round-robin pointer moves past the requester just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_next;
    end
  end

  // Issue stage: load on grant, empty on an idle advance, hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_id_q    <= '0;
    end else if (iss_adv) begin
      iss_valid_q <= xfer;
      if (xfer) begin
        iss_a_q  <= gnt_a;
        iss_b_q  <= gnt_b;
        iss_id_q <= gnt_id;
      end
    end
  end

  // Result stage: capture the multiplier output; payload frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_id_q      <= '0;
    end else if (res_adv) begin
      res_valid_q <= iss_valid_q;
      if (iss_valid_q) begin
        res_product_q <= mul_product;
        res_id_q      <= iss_id_q;
      end
    end
  end

  assign mul_mplier      = iss_a_q;
  assign mul_mcand       = iss_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign bus.res_id      = res_id_q;
  assign busy            = iss_valid_q || res_valid_q;

endmodule

// File: tb/tb_mplier_rr_sched.sv
// Directed bench for the round-robin multiplier scheduler.
module tb_mplier_rr_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mul_mplier;
  logic [31:0] mul_mcand;
  logic [63:0] mul_product;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];
  logic [NREQ-1:0] vld;

  mplier_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mplier_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mul_mplier  (mul_mplier),
    .mul_mcand   (mul_mcand),
    .mul_product (mul_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared signed multiplier
  assign mul_product = $signed({{32{mul_mplier[31]}}, mul_mplier}) *
                       $signed({{32{mul_mcand[31]}}, mul_mcand});

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_mplier[32*i +: 32] = op_a[i];
      bus.req_mcand[32*i +: 32]  = op_b[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [63:0] prod, input logic [1:0] id);
    check({tag, "_valid"}, {63'd0, bus.res_valid}, 64'd1);
    check({tag, "_prod"}, bus.res_product, prod);
    check({tag, "_id"}, {62'd0, bus.res_id}, {62'd0, id});
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    bus.res_ready = 1'b0;
    drive();
    #1;
    check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
    check("rst_mul_mplier", {32'd0, mul_mplier}, 64'd0);
    check("rst_res_product", bus.res_product, 64'd0);
    check("rst_res_id", {62'd0, bus.res_id}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single op on req0: 3 x 5
    op_a[0] = 32'd3; op_b[0] = 32'd5; vld = 4'b0001; bus.res_ready = 1'b1; drive();
    #1;
    check("t1_ready", {60'd0, bus.req_ready}, 64'h1);
    tick();
    vld = 4'b0000; drive();
    #1;
    check("t1_ready_drop", {60'd0, bus.req_ready}, 64'h0);
    check("t1_mul_mplier", {32'd0, mul_mplier}, 64'd3);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_no_res_yet", {63'd0, bus.res_valid}, 64'd0);
    tick();
    check_res("t1_res", 64'h0000_0000_0000_000F, 2'd0);
    tick();
    check("t1_drained", {63'd0, bus.res_valid}, 64'd0);

    // req2: -7 x 6 (ptr=1, so req2 is next in line)
    op_a[2] = 32'hFFFF_FFF9; op_b[2] = 32'd6; vld = 4'b0100; drive();
    #1;
    check("t2_ready", {60'd0, bus.req_ready}, 64'h4);
    tick();
    vld = 4'b0000; drive();
    tick();
    check_res("t2_res", 64'hFFFF_FFFF_FFFF_FFD6, 2'd2);
    tick();

    // req3: most negative squared (ptr=3)
    op_a[3] = 32'h8000_0000; op_b[3] = 32'h8000_0000; vld = 4'b1000; drive();
    #1;
    check("t2b_ready", {60'd0, bus.req_ready}, 64'h8);
    tick();
    vld = 4'b0000; drive();
    tick();
    check_res("t2b_res", 64'h4000_0000_0000_0000, 2'd3);
    tick();

    // All four streaming from ptr=0: grants 0,1,2,3,0,1 back to back
    for (int i = 0; i < int'(NREQ); i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'(10 * (i + 1));
    end
    vld = 4'b1111; drive();
    #1;
    check("t3_g0", {60'd0, bus.req_ready}, 64'h1);
    tick();
    check("t3_g1", {60'd0, bus.req_ready}, 64'h2);
    tick();
    check("t3_g2", {60'd0, bus.req_ready}, 64'h4);
    check_res("t3_r0", 64'd10, 2'd0);
    tick();
    check("t3_g3", {60'd0, bus.req_ready}, 64'h8);
    check_res("t3_r1", 64'd40, 2'd1);
    tick();
    check("t3_g0b", {60'd0, bus.req_ready}, 64'h1);
    check_res("t3_r2", 64'd90, 2'd2);
    tick();
    check("t3_g1b", {60'd0, bus.req_ready}, 64'h2);
    check_res("t3_r3", 64'd160, 2'd3);
    tick();
    vld = 4'b0000; drive();
    check_res("t3_r0b", 64'd10, 2'd0);
    tick();
    check_res("t3_r1b", 64'd40, 2'd1);
    tick();
    check("t3_drained", {63'd0, bus.res_valid}, 64'd0);

    // ptr=2, only req1 and req3 valid: grants 3, 1, 3
    vld = 4'b1010; drive();
    #1;
    check("t4_g3", {60'd0, bus.req_ready}, 64'h8);
    tick();
    check("t4_g1", {60'd0, bus.req_ready}, 64'h2);
    tick();
    check("t4_g3b", {60'd0, bus.req_ready}, 64'h8);
    check_res("t4_r3", 64'd160, 2'd3);
    tick();
    vld = 4'b0000; drive();
    check_res("t4_r1", 64'd40, 2'd1);
    tick();
    check_res("t4_r3b", 64'd160, 2'd3);
    tick();

    // Stall: res_ready=0, req0 streaming; only two ops fit
    bus.res_ready = 1'b0;
    op_a[0] = 32'd7; op_b[0] = 32'hFFFF_FFFD; vld = 4'b0001; drive();
    #1;
    check("t5_acc1", {60'd0, bus.req_ready}, 64'h1);
    tick();
    op_a[0] = 32'd9; op_b[0] = 32'd9; drive();
    check("t5_acc2", {60'd0, bus.req_ready}, 64'h1);
    tick();
    op_a[0] = 32'd5; op_b[0] = 32'd5; drive();
    #1;
    check("t5_full", {60'd0, bus.req_ready}, 64'h0);
    check_res("t5_hold0", 64'hFFFF_FFFF_FFFF_FFEB, 2'd0);
    tick();
    tick();
    check("t5_still_full", {60'd0, bus.req_ready}, 64'h0);
    check_res("t5_hold2", 64'hFFFF_FFFF_FFFF_FFEB, 2'd0);
    check("t5_busy", {63'd0, busy}, 64'd1);
    bus.res_ready = 1'b1; vld = 4'b0000; drive();
    tick();
    check_res("t5_drain2", 64'd81, 2'd0);
    tick();
    check("t5_drained", {63'd0, bus.res_valid}, 64'd0);
    check("t5_idle", {63'd0, busy}, 64'd0);

    // Fill both stages via req1 (ptr -> 2), then reset asynchronously
    bus.res_ready = 1'b0;
    op_a[1] = 32'd11; op_b[1] = 32'd11; vld = 4'b0010; drive();
    tick();
    tick();
    vld = 4'b0000; drive();
    check("t6_full_valid", {63'd0, bus.res_valid}, 64'd1);
    check("t6_full_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {63'd0, bus.res_valid}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_prod", bus.res_product, 64'd0);
    check("t6_rst_mplier", {32'd0, mul_mplier}, 64'd0);
    tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    op_a[1] = 32'd2; op_b[1] = 32'd20; vld = 4'b1010; drive();
    #1;
    check("t6_ptr0_grant", {60'd0, bus.req_ready}, 64'h2);
    tick();
    vld = 4'b0000; drive();
    tick();
    check_res("t6_res", 64'd40, 2'd1);
    tick();
    check("t6_end_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mplier_rr_sched.md
Name: mplier_rr_sched

Overview:
- Round-robin scheduler that shares one combinational 32x32 signed radix-8 Booth multiplier among NREQ requesters.
- Grants one request per cycle and registers the granted operands into an issue stage that drives the shared multiplier.
- Captures the 64-bit product into a result stage tagged with the requester id.
- Full valid/ready handshakes on both sides; stall propagates back to grant.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_mplier  input  NREQ*32  multipliers, requester i at bits [32i+31:32i].
- req_mcand  input  NREQ*32  multiplicands, same packing.
- mul_mplier  output  32  to shared multiplier.
- mul_mcand  output  32  to shared multiplier.
- mul_product  input  64  combinational signed product from shared multiplier.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_product  output  64  signed two's-complement product.
- res_id  output  IDW  index of the requester that issued the operation.
- busy  output  1  issue or result stage occupied.

Behaviour:
- Reset (async, rst_n=0): iss_valid=0, res_valid=0, req_ready=0, rr pointer=0, mul_mplier=0, mul_mcand=0, res_product=0, res_id=0, busy=0. Reset mid-operation discards all in-flight ops with no result produced.
- Stage registers: issue stage {iss_valid, a, b, id} and result stage {res_valid, product, id}.
- res_adv = !res_valid || res_ready.
- iss_adv = !iss_valid || res_adv.
- Grant (combinational): when iss_adv=1, grant the lowest index i >= ptr with req_valid[i]=1, else wrap to the lowest index < ptr. req_ready[i]=1 only for the granted i. All req_ready=0 when iss_adv=0. req_ready must not depend on res_valid except through iss_adv.
- Transfer on requester i occurs when req_valid[i] && req_ready[i]. At that edge the issue stage loads operands and id=i, and ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- If iss_adv=1 and no grant: iss_valid <= 0 and operands hold their last values.
- mul_mplier/mul_mcand are driven directly from the issue-stage registers.
- When res_adv=1: res_valid <= iss_valid. If iss_valid=1: res_product <= mul_product and res_id <= iss id. If iss_valid=0, payload holds.
- When res_adv=0: result stage and issue stage hold. Payload stays stable while res_valid=1 && res_ready=0.
- Latency: accept at edge k gives res_valid=1 after edge k+1.
- Throughput: 1 op/cycle with res_ready held high.
- Pipeline capacity is 2 ops. With res_ready=0, at most 2 accepts occur, then all req_ready=0.
- Simultaneous result pop and new accept in the same cycle is legal and loses no bubble.
- Requesters must hold valid and payload until accepted; the block does not check this.
- Arithmetic: operands are signed 32-bit two's complement; product is full 64-bit; no truncation or saturation.
- busy = iss_valid || res_valid.
- With NREQ not a power of two, ptr wraps at NREQ and res_id never exceeds NREQ-1.

Test Plan:
- Req0 mplier=3, mcand=5, res_ready=1 -> req_ready[0]=1 one cycle; res_valid after 2 edges with product=0x0000_0000_0000_000F, id=0.
- Req2 mplier=-7 (0xFFFF_FFF9), mcand=6 -> product=0xFFFF_FFFF_FFFF_FFD6, id=2. Also 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000.
- All 4 requesters continuously valid, res_ready=1 -> grant/res_id sequence 0,1,2,3,0,1 with one result per cycle and no gaps.
- Ptr=2 with only req1 and req3 valid -> grants 3, then 1, then 3.
- res_ready=0 with req0 streaming -> exactly 2 accepts, then req_ready=0. res_product stays stable while stalled. Raising res_ready drains both results in order with no loss or duplication.
- rst_n pulsed low while both stages are full -> res_valid=0 and busy=0 immediately (asynchronous). After release, a first grant to req1 (req0 idle) shows ptr restarted at 0.
